// File: rtl/rv_pack_if.sv
// Handshake bundle for rv_pack: beat stream in, packed word stream out.
// master drives beats and downstream ready; slave is the packer itself.
interface rv_pack_if #(
  parameter int WD = 4,
  parameter int N  = 4
);
  localparam int CW = $clog2(N) + 1;

  logic              in_val;
  logic              in_rdy;
  logic [WD-1:0]     in_data;
  logic              in_last;
  logic              out_val;
  logic              out_rdy;
  logic [N*WD-1:0]   out_data;
  logic [CW-1:0]     out_cnt;
  logic              out_last;

  modport master (
    output in_val, in_data, in_last, out_rdy,
    input  in_rdy, out_val, out_data, out_cnt, out_last
  );

  modport slave (
    input  in_val, in_data, in_last, out_rdy,
    output in_rdy, out_val, out_data, out_cnt, out_last
  );
endinterface

// File: rtl/rv_pack.sv
// rv_pack: packs up to N beats of WD bits into one word, first beat in the
// low slot. A word closes when slot N-1 is filled or a beat carries in_last.
// One output holding register; back-to-back words flow without a bubble.
module rv_pack #(
  parameter int WD = 4,
  parameter int N  = 4
) (
  input logic      clk,
  input logic      rst,
  rv_pack_if.slave bus
);
  localparam int CNTW = $clog2(N);
  localparam int CW   = CNTW + 1;

  logic [N-2:0][WD-1:0] asm_q;     // beats 0..N-2 of the word in progress
  logic [CNTW-1:0]      cnt;       // next free slot
  logic [N-1:0][WD-1:0] word_q;    // holding register
  logic [N-1:0][WD-1:0] word_d;
  logic [CW-1:0]        ocnt_q;
  logic                 olast_q;
  logic                 oval_q;

  logic in_rdy, in_fire, out_fire, cnt_full, complete;

  // Ready only depends on the holding register being free or draining.
  assign in_rdy   = ~oval_q | bus.out_rdy;
  assign in_fire  = bus.in_val & in_rdy;
  assign out_fire = oval_q & bus.out_rdy;
  assign cnt_full = (cnt == CNTW'(N - 1));
  assign complete = in_fire & (cnt_full | bus.in_last);

  // Next word: stored beats below cnt, the incoming beat at cnt, zero above.
  // Stale assembly contents above cnt are masked here, so they never leak.
  for (genvar k = 0; k < N; k++) begin : g_slot
    if (k < N - 1) begin : g_asm
      assign word_d[k] = (CNTW'(k) < cnt)  ? asm_q[k]    :
                         (CNTW'(k) == cnt) ? bus.in_data : '0;

      // Capture a non-completing beat into its slot.
      always_ff @(posedge clk) begin
        if (rst)                                     asm_q[k] <= '0;
        else if (in_fire && !complete && cnt == CNTW'(k)) asm_q[k] <= bus.in_data;
      end
    end else begin : g_top
      assign word_d[k] = cnt_full ? bus.in_data : '0;
    end
  end

  // Beat counter and output holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      word_q  <= '0;
      ocnt_q  <= '0;
      olast_q <= 1'b0;
      oval_q  <= 1'b0;
    end else if (complete) begin
      // Either the holder was empty or it is being taken this cycle.
      word_q  <= word_d;
      ocnt_q  <= {1'b0, cnt} + CW'(1);
      olast_q <= bus.in_last;
      oval_q  <= 1'b1;
      cnt     <= '0;
    end else begin
      if (in_fire)  cnt    <= cnt + 1'b1;
      if (out_fire) oval_q <= 1'b0;
    end
  end

  assign bus.in_rdy   = in_rdy;
  assign bus.out_val  = oval_q;
  assign bus.out_data = word_q;
  assign bus.out_cnt  = ocnt_q;
  assign bus.out_last = olast_q;
endmodule

// File: tb/tb_rv_pack.sv
// Directed table-driven bench for rv_pack with WD=4, N=4.
module tb_rv_pack;
  localparam int WD = 4;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  rv_pack_if #(.WD(WD), .N(N)) bus ();
  rv_pack #(.WD(WD), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  d;
    logic        l;
    logic        r;
    logic        e_rdy;
    logic        e_val;
    logic [15:0] e_data;
    logic [2:0]  e_cnt;
    logic        e_last;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [3:0] d, input logic l, input logic r,
                     input logic e_rdy, input logic e_val, input logic [15:0] e_data,
                     input logic [2:0] e_cnt, input logic e_last);
    vec_t x;
    x = '{v, d, l, r, e_rdy, e_val, e_data, e_cnt, e_last};
    tbl.push_back(x);
  endtask

  task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic l, input logic r);
    bus.in_val  = v;
    bus.in_data = d;
    bus.in_last = l;
    bus.out_rdy = r;
  endtask

  // Compare outputs; payload fields only meaningful while out_val is expected high.
  task automatic check_out(input string nm, input int idx, input logic e_rdy, input logic e_val,
                           input logic [15:0] e_data, input logic [2:0] e_cnt, input logic e_last);
    cmp({nm, ".rdy"}, idx, 32'(bus.in_rdy), 32'(e_rdy));
    cmp({nm, ".val"}, idx, 32'(bus.out_val), 32'(e_val));
    if (e_val) begin
      cmp({nm, ".data"}, idx, 32'(bus.out_data), 32'(e_data));
      cmp({nm, ".cnt"},  idx, 32'(bus.out_cnt),  32'(e_cnt));
      cmp({nm, ".last"}, idx, 32'(bus.out_last), 32'(e_last));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Full word, out_rdy=1
    add(1,4'h1,0,1, 1,0,16'h0,0,0);
    add(1,4'h2,0,1, 1,0,16'h0,0,0);
    add(1,4'h3,0,1, 1,0,16'h0,0,0);
    add(1,4'h4,0,1, 1,0,16'h0,0,0);
    add(0,4'h0,0,1, 1,1,16'h4321,4,0);
    // Early close with in_last, next beat lands in slot 0
    add(1,4'hA,0,1, 1,0,16'h0,0,0);
    add(1,4'hB,1,1, 1,0,16'h0,0,0);
    add(1,4'hC,0,1, 1,1,16'h00BA,2,1);
    add(1,4'hD,1,1, 1,0,16'h0,0,0);
    add(0,4'h0,0,1, 1,1,16'h00DC,2,1);
    // Continuous stream 1..8
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) add(1,4'(i),0,1, 1,1,16'h4321,4,0);
      else        add(1,4'(i),0,1, 1,0,16'h0,0,0);
    end
    add(0,4'h0,0,1, 1,1,16'h8765,4,0);
    add(0,4'h0,0,1, 1,0,16'h0,0,0);
    // Backpressure: beats accepted while holder empty, then stall 5 cycles
    add(1,4'h1,0,0, 1,0,16'h0,0,0);
    add(1,4'h2,0,0, 1,0,16'h0,0,0);
    add(1,4'h3,0,0, 1,0,16'h0,0,0);
    add(1,4'h4,0,0, 1,0,16'h0,0,0);
    for (int i = 0; i < 5; i++) add(1,4'h5,1,0, 0,1,16'h4321,4,0);
    // Release: take word and accept completing beat same cycle, no bubble
    add(1,4'h5,1,1, 1,1,16'h4321,4,0);
    add(1,4'h6,1,1, 1,1,16'h0005,1,1);
    add(0,4'h0,0,1, 1,1,16'h0006,1,1);
    // Full word closed by in_last at slot N-1
    add(1,4'h1,0,1, 1,0,16'h0,0,0);
    add(1,4'h2,0,1, 1,0,16'h0,0,0);
    add(1,4'h3,0,1, 1,0,16'h0,0,0);
    add(1,4'h4,1,1, 1,0,16'h0,0,0);
    add(0,4'h0,0,0, 0,1,16'h4321,4,1);
    add(0,4'h0,0,1, 1,1,16'h4321,4,1);
    add(0,4'h0,0,1, 1,0,16'h0,0,0);

    // Reset with junk traffic present
    rst = 1'b1;
    drive(1, 4'hF, 0, 1);
    tick();
    tick();
    cmp("rst.val",  0, 32'(bus.out_val),  32'd0);
    cmp("rst.cnt",  0, 32'(bus.out_cnt),  32'd0);
    cmp("rst.last", 0, 32'(bus.out_last), 32'd0);
    cmp("rst.data", 0, 32'(bus.out_data), 32'd0);
    rst = 1'b0;
    drive(0, 4'h0, 0, 1);
    #1;
    cmp("rst.rdy",  0, 32'(bus.in_rdy),   32'd1);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
      #1;
      check_out("vec", i, tbl[i].e_rdy, tbl[i].e_val, tbl[i].e_data, tbl[i].e_cnt, tbl[i].e_last);
      tick();
    end

    // Reset mid-word discards beats 1,2
    drive(1, 4'h1, 0, 1); tick();
    drive(1, 4'h2, 0, 1); tick();
    rst = 1'b1;
    drive(0, 4'h0, 0, 1);
    tick();
    rst = 1'b0;
    cmp("mid.val", 0, 32'(bus.out_val), 32'd0);
    cmp("mid.cnt", 0, 32'(bus.out_cnt), 32'd0);
    cmp("mid.rdy", 0, 32'(bus.in_rdy),  32'd1);
    drive(1, 4'h9, 0, 1); tick();
    drive(1, 4'hA, 0, 1); tick();
    drive(1, 4'hB, 0, 1); tick();
    drive(1, 4'hC, 0, 1); tick();
    drive(0, 4'h0, 0, 1);
    #1;
    check_out("mid", 1, 1'b1, 1'b1, 16'hCBA9, 3'd4, 1'b0);
    tick();
    cmp("mid.drain", 2, 32'(bus.out_val), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
